div32: RTL and testbench

DIV32 -- requirements
Module: div32

---
 rtl/alu_pkg.sv | 18 +
 rtl/div_step.sv | 25 ++
 rtl/div32.sv | 151 +++++++++++++++
 tb/tb_div32.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, datapath width and divide-by-zero result.
// Also holds the conditional two's-complement negate helper used by the signed divider build.
package alu_pkg;

    localparam int WIDTH = 32;
    localparam logic [WIDTH-1:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract the divisor, keep or restore.
// Purely combinational, no handshake; the caller sequences one step per clock.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             q_bit
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] trial;

    // rem_in is always below the divisor, so the shifted value never reaches the top bit
    // and a borrow shows up directly as trial's sign bit.
    always_comb begin
        shifted = {rem_in, dvd_bit};
        trial   = shifted - {2'b00, divisor};
        q_bit   = ~trial[WIDTH+1];
        rem_out = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
    end

endmodule

// File: rtl/div32.sv
// div32: restoring divider, done high in the cycle after the 33rd edge following start (1st edge if b == 0).
// No backpressure: start is only taken in IDLE/DONE and ignored while busy. DIV32_SIGNED_EN adds sign_op.
module div32 #(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef DIV32_SIGNED_EN
    input  logic             sign_op,
`endif
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);
    import alu_pkg::*;

    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    div_state_t       state, next_state;
    logic [1:0]       rst_sync;
    logic             rst_ok;
    logic             pend;
    logic             accept;
    logic [5:0]       cnt;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] dsr;
    logic [WIDTH:0]   rem;
    logic [WIDTH:0]   rem_next;
    logic             q_bit;
    logic [WIDTH-1:0] a_load;
    logic [WIDTH-1:0] b_load;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] zero_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_sync <= '0;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end
    assign rst_ok = rst_sync[1];

    // The accepting edge only captures operands; pend blocks a second capture until the FSM moves.
    assign accept = rst_ok & start & ~pend & ((state == IDLE) | (state == DONE));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem),
        .dvd_bit (dvd[WIDTH-1]),
        .divisor (dsr),
        .rem_out (rem_next),
        .q_bit   (q_bit)
    );

`ifdef DIV32_SIGNED_EN
    logic a_neg, q_neg;
    logic a_neg_load, b_neg_load;

    always_comb begin
        a_neg_load = sign_op & a[WIDTH-1];
        b_neg_load = sign_op & b[WIDTH-1];
        a_load     = neg_if(a, a_neg_load);
        b_load     = neg_if(b, b_neg_load);
        res_q      = neg_if({dvd[WIDTH-2:0], q_bit}, q_neg);
        res_r      = neg_if(rem_next[WIDTH-1:0], a_neg);
        zero_r     = neg_if(dvd, a_neg);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_neg <= 1'b0;
            q_neg <= 1'b0;
        end else if (accept) begin
            a_neg <= a_neg_load;
            q_neg <= a_neg_load ^ b_neg_load;
        end
    end
`else
    always_comb begin
        a_load = a;
        b_load = b;
        res_q  = {dvd[WIDTH-2:0], q_bit};
        res_r  = rem_next[WIDTH-1:0];
        zero_r = dvd;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (pend) next_state = (dsr == '0) ? DONE : RUN;
            RUN:     if (cnt == LAST_ITER) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // dvd shifts left each iteration; quotient bits fill in from the bottom.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend        <= 1'b0;
            cnt         <= '0;
            dvd         <= '0;
            dsr         <= '0;
            rem         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            pend <= 1'b1;
            cnt  <= '0;
            rem  <= '0;
            dvd  <= a_load;
            dsr  <= b_load;
        end else if (state == IDLE && pend) begin
            pend <= 1'b0;
            if (dsr == '0) begin
                quotient    <= DIV_ZERO_QUOTIENT;
                remainder   <= zero_r;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            cnt <= cnt + 6'd1;
            dvd <= {dvd[WIDTH-2:0], q_bit};
            rem <= rem_next;
            if (cnt == LAST_ITER) begin
                quotient    <= res_q;
                remainder   <= res_r;
                div_by_zero <= 1'b0;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_div32.sv
// Self-checking bench for div32: directed and random operations, scoreboard queue with a decoupled monitor.
module tb_div32;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
`ifdef DIV32_SIGNED_EN
    logic        sign_op;
`endif
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    div32 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .a           (a),
        .b           (b),
`ifdef DIV32_SIGNED_EN
        .sign_op     (sign_op),
`endif
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain arithmetic on the operands; done expected 33 edges after acceptance, 1 for b == 0.
    function automatic exp_t model(input logic [31:0] ai, input logic [31:0] bi, input bit si, input int acc);
        exp_t   e;
        longint sa;
        longint sd;
        if (bi == 32'd0) begin
            e.q   = 32'hFFFF_FFFF;
            e.r   = ai;
            e.dz  = 1'b1;
            e.cyc = acc + 1;
        end else begin
            if (si) begin
                sa  = longint'($signed(ai));
                sd  = longint'($signed(bi));
                e.q = 32'(sa / sd);
                e.r = 32'(sa % sd);
            end else begin
                e.q = ai / bi;
                e.r = ai % bi;
            end
            e.dz  = 1'b0;
            e.cyc = acc + 33;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Call at a negedge; returns just after the accepting edge.
    task automatic issue(input logic [31:0] ai, input logic [31:0] bi, input bit si);
        start = 1'b1;
        a     = ai;
        b     = bi;
`ifdef DIV32_SIGNED_EN
        sign_op = si;
`endif
        @(posedge clk);
        #1;
        exp_q.push_back(model(ai, bi, si, cyc));
        start = 1'b0;
    endtask

    task automatic wait_idle(output int bc);
        int n;
        bc = 0;
        n  = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            if (busy) bc++;
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: %0d results still outstanding after %0d cycles", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    initial begin
        int          bc;
        int          acc;
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rs;

        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef DIV32_SIGNED_EN
        sign_op = 1'b0;
`endif

        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (rst && done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: q=0x%08h r=0x%08h at cycle %0d", quotient, remainder, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        chk("done_cycle", 32'(cyc), 32'(e.cyc));
                        chk("quotient", quotient, e.q);
                        chk("remainder", remainder, e.r);
                        chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_quotient", quotient, 32'd0);
        chk("rst_remainder", remainder, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_div_by_zero", {31'd0, div_by_zero}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        issue(32'd100, 32'd7, 1'b0);
        wait_idle(bc);
        chk("busy_cycles_100_7", 32'(bc), 32'd32);

        issue(32'd5, 32'd0, 1'b0);
        wait_idle(bc);
        chk("busy_cycles_div0", 32'(bc), 32'd0);

        // Re-pulse of start ten edges into the run must be ignored.
        issue(32'hFFFF_FFFF, 32'd1, 1'b0);
        repeat (10) @(negedge clk);
        start = 1'b1;
        a     = 32'd3;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(bc);
        repeat (40) @(negedge clk);

        // Start held high: accepted at acc, acc+34, acc+68.
        start = 1'b1;
        a     = 32'd20;
        b     = 32'd6;
        @(posedge clk);
        #1;
        acc = cyc;
        exp_q.push_back(model(32'd20, 32'd6, 1'b0, acc));
        exp_q.push_back(model(32'd20, 32'd6, 1'b0, acc + 34));
        exp_q.push_back(model(32'd20, 32'd6, 1'b0, acc + 68));
        repeat (68) @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(bc);
        repeat (40) @(negedge clk);

        // Reset 15 edges into an operation: aborted, no done, outputs cleared at once.
        start = 1'b1;
        a     = 32'd1000;
        b     = 32'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_quotient", quotient, 32'd0);
        chk("abort_remainder", remainder, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_div_by_zero", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        a     = 32'd9;
        b     = 32'd4;
        // Only the third edge after release may take the request.
        repeat (3) @(posedge clk);
        #1;
        exp_q.push_back(model(32'd9, 32'd4, 1'b0, cyc));
        start = 1'b0;
        wait_idle(bc);

`ifdef DIV32_SIGNED_EN
        issue(32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle(bc);
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle(bc);
`endif

        for (int i = 0; i < 24; i++) begin
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2, 3: rb = 32'($urandom_range(1, 255));
                4:       rb = 32'd1;
                default: rb = $urandom;
            endcase
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
`ifdef DIV32_SIGNED_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            issue(ra, rb, rs);
            wait_idle(bc);
            chk("busy_cycles_rand", 32'(bc), (rb == 32'd0) ? 32'd0 : 32'd32);
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
